// File: rtl/rc_capture_pkg.sv
// rtl/rc_capture_pkg.sv - shared parameters, word layout and output-stage states for the capture arbiter
package rc_capture_pkg;

  localparam int CNT_W_DEF = 31;
  localparam int CH_W_DEF  = 4;

  // Output word layout: {ch_idx, level, width}, width field at the bottom.
  localparam int WIDTH_LSB = 0;

  function automatic int level_pos(input int cnt_w);
    return cnt_w;
  endfunction

  function automatic int idx_lsb(input int cnt_w);
    return cnt_w + 1;
  endfunction

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/rc_capture_arbiter_rr.sv
// rtl/rc_capture_arbiter_rr.sv - combinational round-robin pick: first request at or above the pointer, wrapping
module rc_rr_arbiter #(
  parameter int NUM_CH = 8,
  parameter int IW     = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IW-1:0]     ptr_i,
  output logic [NUM_CH-1:0] grant_o,
  output logic [IW-1:0]     idx_o,
  output logic              any_o
);

  always_comb begin
    logic [IW-1:0] j;
    logic          found;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    j       = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      j = IW'((int'(ptr_i) + k) % NUM_CH);
      if (!found && req_i[j]) begin
        found      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = j;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/rc_capture_arbiter.sv
// rtl/rc_capture_arbiter.sv - per-channel pulse capture slots merged round-robin onto one tagged valid/ready stream
module rc_capture_arbiter
  import rc_capture_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int CH_W   = CH_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH-1:0]       ch_rdy,
  input  logic [NUM_CH-1:0]       ch_value,
  input  logic [NUM_CH*CNT_W-1:0] ch_counter,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [CH_W+CNT_W:0]     m_data,
  output logic [NUM_CH-1:0]       overrun,
  input  logic [NUM_CH-1:0]       overrun_clr,
  output logic [15:0]             drop_count
);

  localparam int IW        = $clog2(NUM_CH);
  localparam int DW        = CH_W + 1 + CNT_W;
  localparam int LEVEL_POS = level_pos(CNT_W);
  localparam int IDX_LSB   = idx_lsb(CNT_W);

  logic [CNT_W:0]    slot_q [NUM_CH];
  logic [CNT_W:0]    slot_d [NUM_CH];
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] overrun_q, overrun_d;
  logic [15:0]       drop_q, drop_d;
  out_state_e        state_q;
  logic              valid_q;
  logic [DW-1:0]     data_q;
  logic [IW-1:0]     rr_ptr_q;

  logic [NUM_CH-1:0] grant;
  logic [IW-1:0]     win_idx;
  logic              any_pend;
  logic              load;
  logic [NUM_CH-1:0] drain_oh;
  logic [NUM_CH-1:0] ovw;
  logic [4:0]        ovw_cnt;
  logic [16:0]       drop_sum;
  logic [DW-1:0]     load_word;

  rc_rr_arbiter #(.NUM_CH(NUM_CH), .IW(IW)) u_rr (
    .req_i   (pending_q),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .idx_o   (win_idx),
    .any_o   (any_pend)
  );

  assign load     = (state_q == ST_EMPTY) || m_ready;
  assign drain_oh = grant & {NUM_CH{load}};

  always_comb begin
    slot_d    = slot_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    ovw       = '0;
    ovw_cnt   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      // A slot drained on this edge may take a fresh capture without counting as a loss.
      ovw[i] = ch_rdy[i] & ch_en[i] & pending_q[i] & ~drain_oh[i];
      if (ch_rdy[i] && ch_en[i]) begin
        slot_d[i] = {ch_value[i], ch_counter[i*CNT_W +: CNT_W]};
      end
      if (!ch_en[i]) begin
        pending_d[i] = 1'b0;
      end else if (ch_rdy[i]) begin
        pending_d[i] = 1'b1;
      end else if (drain_oh[i]) begin
        pending_d[i] = 1'b0;
      end
      overrun_d[i] = ovw[i] | (overrun_q[i] & ~overrun_clr[i]);
      ovw_cnt      = ovw_cnt + 5'(ovw[i]);
    end
    drop_sum = {1'b0, drop_q} + 17'(ovw_cnt);
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_comb begin
    load_word                      = '0;
    load_word[IDX_LSB +: CH_W]     = CH_W'(win_idx);
    load_word[LEVEL_POS]           = slot_q[win_idx][CNT_W];
    load_word[WIDTH_LSB +: CNT_W]  = slot_q[win_idx][CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) slot_q[i] <= '0;
      pending_q <= '0;
      overrun_q <= '0;
      drop_q    <= '0;
    end else begin
      slot_q    <= slot_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      drop_q    <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_EMPTY;
      valid_q  <= 1'b0;
      data_q   <= '0;
      rr_ptr_q <= '0;
    end else if (load) begin
      if (any_pend) begin
        state_q  <= ST_FULL;
        valid_q  <= 1'b1;
        data_q   <= load_word;
        rr_ptr_q <= (win_idx == IW'(NUM_CH - 1)) ? '0 : win_idx + 1'b1;
      end else begin
        state_q <= ST_EMPTY;
        valid_q <= 1'b0;
      end
    end
  end

  assign m_valid    = valid_q;
  assign m_data     = data_q;
  assign overrun    = overrun_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_rc_capture_arbiter.sv
// tb/tb_rc_capture_arbiter.sv - vector table, directed corner sequences and randomized run against a behavioural model
module tb_rc_capture_arbiter;

  localparam int NUM_CH = 8;
  localparam int CNT_W  = 31;
  localparam int CH_W   = 4;
  localparam int DW     = CH_W + 1 + CNT_W;

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic [NUM_CH-1:0]       ch_en, ch_rdy, ch_value, overrun_clr;
  logic [NUM_CH*CNT_W-1:0] ch_counter;
  logic                    m_ready;
  logic                    m_valid;
  logic [DW-1:0]           m_data;
  logic [NUM_CH-1:0]       overrun;
  logic [15:0]             drop_count;

  always #5 clk = ~clk;

  rc_capture_arbiter #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .CH_W(CH_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ch_en       (ch_en),
    .ch_rdy      (ch_rdy),
    .ch_value    (ch_value),
    .ch_counter  (ch_counter),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
    .drop_count  (drop_count)
  );

  int errors = 0;
  int checks = 0;
  int cyc_no = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_no);
    end
  endtask

  function automatic logic [DW-1:0] w(input int ch, input bit lv, input int c);
    logic [CH_W-1:0]  f_ch;
    logic [CNT_W-1:0] f_c;
    f_ch = CH_W'(ch);
    f_c  = CNT_W'(c);
    return {f_ch, lv, f_c};
  endfunction

  // Behavioural reference: slots as arrays, arbitration as a plain wrapped search.
  bit               md_pend [NUM_CH];
  logic [CNT_W:0]   md_slot [NUM_CH];
  bit               md_ovr  [NUM_CH];
  int               md_drop;
  bit               md_vld;
  logic [DW-1:0]    md_dat;
  int               md_ptr;

  task automatic model_step();
    int  win;
    bit  old_pend [NUM_CH];
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        md_pend[i] = 0; md_slot[i] = '0; md_ovr[i] = 0;
      end
      md_drop = 0; md_vld = 0; md_dat = '0; md_ptr = 0;
      return;
    end
    win = -1;
    old_pend = md_pend;
    if (!md_vld || m_ready) begin
      for (int k = 0; k < NUM_CH; k++) begin
        int j;
        j = (md_ptr + k) % NUM_CH;
        if (win < 0 && old_pend[j]) win = j;
      end
      if (win >= 0) begin
        md_dat = w(win, md_slot[win][CNT_W], int'(md_slot[win][CNT_W-1:0]));
        md_vld = 1;
        md_ptr = (win + 1) % NUM_CH;
        md_pend[win] = 0;
      end else begin
        md_vld = 0;
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (overrun_clr[i]) md_ovr[i] = 0;
      if (ch_en[i] && ch_rdy[i]) begin
        if (old_pend[i] && i != win) begin
          md_ovr[i] = 1;
          if (md_drop < 65535) md_drop++;
        end
        md_slot[i] = {ch_value[i], ch_counter[i*CNT_W +: CNT_W]};
        md_pend[i] = 1;
      end
      if (!ch_en[i]) md_pend[i] = 0;
    end
  endtask

  logic [DW-1:0] got [$];
  int            got_cyc [$];

  task automatic tick();
    logic [NUM_CH-1:0] ovr_v;
    if (reset_n && m_valid && m_ready) begin
      got.push_back(m_data);
      got_cyc.push_back(cyc_no);
    end
    model_step();
    @(posedge clk);
    #1;
    cyc_no++;
    for (int i = 0; i < NUM_CH; i++) ovr_v[i] = md_ovr[i];
    chk("m_valid", 64'(m_valid), 64'(md_vld));
    chk("m_data", 64'(m_data), 64'(md_dat));
    chk("overrun", 64'(overrun), 64'(ovr_v));
    chk("drop_count", 64'(drop_count), 64'(md_drop));
  endtask

  task automatic idle(input int n, input logic rd);
    ch_rdy = '0; overrun_clr = '0; m_ready = rd;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0; ch_en = '1; ch_rdy = '0; ch_value = '0; ch_counter = '0;
    overrun_clr = '0; m_ready = 1'b1;
    tick(); tick();
    reset_n = 1'b1;
    got.delete(); got_cyc.delete();
  endtask

  task automatic set_cnt_per_ch(input int base);
    for (int i = 0; i < NUM_CH; i++) ch_counter[i*CNT_W +: CNT_W] = CNT_W'(base + i);
  endtask

  typedef struct {
    logic [NUM_CH-1:0] rdy, val, clr;
    int                cnt;
    logic              rd;
    logic              e_vld;
    logic [DW-1:0]     e_dat;
    logic [NUM_CH-1:0] e_ovr;
    logic [15:0]       e_drop;
  } vec_t;

  function automatic vec_t mk(input logic [NUM_CH-1:0] rdy, input logic [NUM_CH-1:0] val,
                              input int cnt, input logic [NUM_CH-1:0] clr, input logic rd,
                              input logic e_vld, input logic [DW-1:0] e_dat,
                              input logic [NUM_CH-1:0] e_ovr, input logic [15:0] e_drop);
    vec_t v;
    v.rdy = rdy; v.val = val; v.cnt = cnt; v.clr = clr; v.rd = rd;
    v.e_vld = e_vld; v.e_dat = e_dat; v.e_ovr = e_ovr; v.e_drop = e_drop;
    return v;
  endfunction

  vec_t tbl [11];

  initial begin
    tbl[0]  = mk(8'h08, 8'h08, 1500, 8'h00, 1'b1, 1'b0, '0,             8'h00, 16'd0);
    tbl[1]  = mk(8'h00, 8'h00, 0,    8'h00, 1'b1, 1'b1, w(3, 1, 1500),  8'h00, 16'd0);
    tbl[2]  = mk(8'h00, 8'h00, 0,    8'h00, 1'b1, 1'b0, '0,             8'h00, 16'd0);
    tbl[3]  = mk(8'h02, 8'h00, 10,   8'h00, 1'b0, 1'b0, '0,             8'h00, 16'd0);
    tbl[4]  = mk(8'h00, 8'h00, 0,    8'h00, 1'b0, 1'b1, w(1, 0, 10),    8'h00, 16'd0);
    tbl[5]  = mk(8'h02, 8'h00, 20,   8'h00, 1'b0, 1'b1, w(1, 0, 10),    8'h00, 16'd0);
    tbl[6]  = mk(8'h02, 8'h00, 30,   8'h00, 1'b0, 1'b1, w(1, 0, 10),    8'h02, 16'd1);
    tbl[7]  = mk(8'h02, 8'h00, 40,   8'h02, 1'b0, 1'b1, w(1, 0, 10),    8'h02, 16'd2);
    tbl[8]  = mk(8'h00, 8'h00, 0,    8'h02, 1'b0, 1'b1, w(1, 0, 10),    8'h00, 16'd2);
    tbl[9]  = mk(8'h00, 8'h00, 0,    8'h00, 1'b1, 1'b1, w(1, 0, 40),    8'h00, 16'd2);
    tbl[10] = mk(8'h00, 8'h00, 0,    8'h00, 1'b1, 1'b0, '0,             8'h00, 16'd2);

    do_reset();
    chk("reset m_valid", 64'(m_valid), 64'd0);
    chk("reset m_data", 64'(m_data), 64'd0);
    chk("reset drop", 64'(drop_count), 64'd0);

    // Table: single event latency, backpressure hold, overwrite and clear priority.
    for (int r = 0; r < 11; r++) begin
      ch_rdy = tbl[r].rdy; ch_value = tbl[r].val; overrun_clr = tbl[r].clr;
      ch_counter = {NUM_CH{CNT_W'(tbl[r].cnt)}}; m_ready = tbl[r].rd;
      tick();
      chk($sformatf("tbl%0d valid", r), 64'(m_valid), 64'(tbl[r].e_vld));
      if (tbl[r].e_vld) chk($sformatf("tbl%0d data", r), 64'(m_data), 64'(tbl[r].e_dat));
      chk($sformatf("tbl%0d overrun", r), 64'(overrun), 64'(tbl[r].e_ovr));
      chk($sformatf("tbl%0d drop", r), 64'(drop_count), 64'(tbl[r].e_drop));
    end

    // Contention from pointer 0, then a second round from pointer 6 wrapping to 0.
    do_reset();
    set_cnt_per_ch(100); ch_value = 8'h05; ch_rdy = 8'h25; m_ready = 1'b1;
    tick();
    idle(5, 1'b1);
    chk("cont n", 64'(got.size()), 64'd3);
    if (got.size() == 3) begin
      chk("cont w0", 64'(got[0]), 64'(w(0, 1, 100)));
      chk("cont w1", 64'(got[1]), 64'(w(2, 1, 102)));
      chk("cont w2", 64'(got[2]), 64'(w(5, 0, 105)));
      chk("cont b2b", 64'(got_cyc[2] - got_cyc[0]), 64'd2);
    end
    got.delete(); got_cyc.delete();
    set_cnt_per_ch(200); ch_value = 8'h20; ch_rdy = 8'h21;
    tick();
    idle(4, 1'b1);
    chk("wrap n", 64'(got.size()), 64'd2);
    if (got.size() == 2) begin
      chk("wrap w0", 64'(got[0]), 64'(w(0, 0, 200)));
      chk("wrap w1", 64'(got[1]), 64'(w(5, 1, 205)));
    end

    // Backpressure: ch1 word held 10 cycles, two more events on ch1 lose one.
    do_reset();
    ch_value = 8'h02; ch_counter = {NUM_CH{CNT_W'(500)}}; ch_rdy = 8'h02; m_ready = 1'b0;
    tick();
    for (int c = 0; c < 10; c++) begin
      ch_rdy = (c == 3 || c == 5) ? 8'h02 : 8'h00;
      ch_counter = {NUM_CH{CNT_W'(c == 3 ? 600 : 700)}};
      tick();
      if (c >= 1) chk("bp hold", 64'(m_data), 64'(w(1, 1, 500)));
    end
    chk("bp overrun", 64'(overrun[1]), 64'd1);
    chk("bp drop", 64'(drop_count), 64'd1);
    idle(3, 1'b1);
    chk("bp n", 64'(got.size()), 64'd2);
    if (got.size() == 2) chk("bp newest", 64'(got[1]), 64'(w(1, 1, 700)));

    // Same-edge drain and new event on ch4.
    do_reset();
    ch_value = 8'h00; ch_counter = {NUM_CH{CNT_W'(41)}}; ch_rdy = 8'h10; m_ready = 1'b1;
    tick();
    ch_counter = {NUM_CH{CNT_W'(42)}}; ch_rdy = 8'h10;
    tick();
    idle(4, 1'b1);
    chk("same n", 64'(got.size()), 64'd2);
    if (got.size() == 2) begin
      chk("same w0", 64'(got[0]), 64'(w(4, 0, 41)));
      chk("same w1", 64'(got[1]), 64'(w(4, 0, 42)));
    end
    chk("same drop", 64'(drop_count), 64'd0);
    chk("same ovr", 64'(overrun), 64'd0);

    // Reset in the middle of a stalled burst, then a disabled channel is ignored.
    ch_rdy = 8'hFF; m_ready = 1'b0; tick();
    ch_rdy = 8'h0F; tick();
    reset_n = 1'b0; ch_rdy = '0; tick();
    chk("mrst valid", 64'(m_valid), 64'd0);
    chk("mrst drop", 64'(drop_count), 64'd0);
    chk("mrst ovr", 64'(overrun), 64'd0);
    reset_n = 1'b1; got.delete(); got_cyc.delete();
    idle(4, 1'b1);
    chk("mrst nopend", 64'(got.size()), 64'd0);
    ch_en = 8'hFE; ch_rdy = 8'h01; tick();
    ch_en = 8'hFF; idle(3, 1'b1);
    chk("dis ignored", 64'(got.size()), 64'd0);

    // Randomized run against the model.
    for (int c = 0; c < 3000; c++) begin
      reset_n     = ($urandom_range(0, 299) != 0);
      ch_en       = NUM_CH'(~($urandom & $urandom & $urandom));
      ch_rdy      = NUM_CH'($urandom & $urandom);
      ch_value    = NUM_CH'($urandom);
      overrun_clr = NUM_CH'($urandom & $urandom & $urandom);
      m_ready     = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < NUM_CH; i++) ch_counter[i*CNT_W +: CNT_W] = CNT_W'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
